credit_pow_stream: RTL and testbench

//   Credit-flow-controlled stream unit: raises each accepted unsigned sample to a compile-time power.

---
 rtl/credit_pow_stream.sv | 197 +++++++++++++++++++
 tb/tb_credit_pow_stream.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_pow_stream.sv
// ---------------------------------------------------------------------------
// credit_pow_stream
//   Credit-flow-controlled stream unit. Each accepted unsigned sample x is
//   raised to x^POWER by a non-stalling multiply pipeline (POWER-1 stages).
//   The result then lands in a DEPTH-entry skid FIFO with a registered output.
//   A credit counter starts at DEPTH and is only replenished by pops, so the
//   pipeline can never deliver a result into a full FIFO.
//
// Ports
//   clk_i    in   1              clock, rising edge
//   rst_i    in   1              synchronous reset, active-low
//   data_i   in   DATA_WIDTH     input sample x (unsigned)
//   valid_i  in   1              upstream valid
//   ready_o  out  1              credit available (registered)
//   data_o   out  POWER*DW       x^POWER, exact
//   valid_o  out  1              FIFO head valid
//   ready_i  in   1              downstream ready
//   credit_o out  CW             current credits   (CREDIT_STATUS_EN only)
//   level_o  out  CW             FIFO occupancy    (CREDIT_STATUS_EN only)
//
// Optional feature macro: CREDIT_STATUS_EN (adds credit_o / level_o).
// ---------------------------------------------------------------------------
module credit_pow_stream #(
  parameter int DATA_WIDTH = 4,
  parameter int POWER      = 5,
  parameter int DEPTH      = 10,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int PW        = POWER * DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [PW-1:0]         data_o,
  output logic                  valid_o,
  input  logic                  ready_i
`ifdef CREDIT_STATUS_EN
  ,
  output logic [CW-1:0]         credit_o,
  output logic [CW-1:0]         level_o
`endif
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (POWER < 2) begin : g_bad_power
      $error("credit_pow_stream: POWER must be >= 2");
    end
    if (DEPTH < 1) begin : g_bad_depth
      $error("credit_pow_stream: DEPTH must be >= 1");
    end
  endgenerate

  logic                  acc;
  logic                  pop;
  logic [CW-1:0]         credits;
  logic [CW-1:0]         credits_next;

  logic [DATA_WIDTH-1:0] x_pipe [POWER-1];
  logic [PW-1:0]         p_pipe [POWER-1];
  logic [POWER-2:0]      v_pipe;

  logic                  wr_en;
  logic [PW-1:0]         wr_data;
  logic [PW-1:0]         mem [DEPTH];
  logic [PTRW-1:0]       wr_ptr;
  logic [PTRW-1:0]       rd_ptr;
  logic [PTRW-1:0]       rd_ptr_next;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;

  assign acc     = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign wr_en   = v_pipe[POWER-2];
  assign wr_data = p_pipe[POWER-2];

  // Credit bookkeeping: an acceptance spends one credit, a pop returns one.
  // Both in the same cycle cancel out.
  always_comb begin
    credits_next = credits;
    if (acc && !pop) begin
      credits_next = credits - CW'(1);
    end else if (!acc && pop) begin
      credits_next = credits + CW'(1);
    end
  end

  // ready_o is registered from the next credit value, so a returned credit
  // shows up on ready_o the cycle after the pop and ready_o is low in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      credits <= CW'(DEPTH);
      ready_o <= 1'b0;
    end else begin
      credits <= credits_next;
      ready_o <= (credits_next != '0);
    end
  end

  // Valid shift register running alongside the multiply stages; the pipeline
  // never stalls, so it simply advances every cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      v_pipe <= '0;
    end else begin
      v_pipe[0] <= acc;
      for (int k = 1; k < POWER - 1; k++) begin
        v_pipe[k] <= v_pipe[k-1];
      end
    end
  end

  // Multiply stages: stage 0 holds x and x^2, stage k holds x and x^(k+2).
  // Products are kept at the full result width so nothing is truncated.
  always_ff @(posedge clk_i) begin
    x_pipe[0] <= data_i;
    p_pipe[0] <= PW'(data_i) * PW'(data_i);
    for (int k = 1; k < POWER - 1; k++) begin
      x_pipe[k] <= x_pipe[k-1];
      p_pipe[k] <= p_pipe[k-1] * PW'(x_pipe[k-1]);
    end
  end

  // Next read pointer and occupancy of the FIFO (count includes the head).
  always_comb begin
    rd_ptr_next = rd_ptr;
    if (pop) begin
      rd_ptr_next = (rd_ptr == PTRW'(DEPTH - 1)) ? '0 : rd_ptr + PTRW'(1);
    end
    count_next = count;
    if (wr_en && !pop) begin
      count_next = count + CW'(1);
    end else if (!wr_en && pop) begin
      count_next = count - CW'(1);
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO control and registered head. When the entry being written is the
  // next head (FIFO otherwise empty after this cycle), it is loaded straight
  // from the write data; it still appears only one cycle after the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PTRW'(DEPTH - 1)) ? '0 : wr_ptr + PTRW'(1);
      end
      rd_ptr  <= rd_ptr_next;
      count   <= count_next;
      valid_o <= (count_next != '0);
      if (count_next != '0) begin
        data_o <= (wr_en && (rd_ptr_next == wr_ptr)) ? wr_data : mem[rd_ptr_next];
      end
    end
  end

`ifdef CREDIT_STATUS_EN
  // Status mirrors of the credit counter and FIFO occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      credit_o <= CW'(DEPTH);
      level_o  <= '0;
    end else begin
      credit_o <= credits_next;
      level_o  <= count_next;
    end
  end

`ifndef SYNTHESIS
  // Every credit is either unspent, riding the pipeline, or sitting in the FIFO.
  a_credit_invariant: assert property (@(posedge clk_i) disable iff (!rst_i)
    (int'(credit_o) + int'(level_o) + $countones(v_pipe)) == DEPTH)
    else $error("credit_pow_stream: credit invariant violated");
`endif
`endif

`ifndef SYNTHESIS
  // The credit scheme makes a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(wr_en && (count == CW'(DEPTH))))
    else $error("credit_pow_stream: write into full FIFO");
`endif

endmodule

// File: tb/tb_credit_pow_stream.sv
// ---------------------------------------------------------------------------
// tb_credit_pow_stream
//   Self-checking bench for credit_pow_stream. Two instances: DEPTH=10 for
//   the directed tests and DEPTH=3 for the starved-credit random run.
//   Reference behaviour is a queue of expected x^POWER values plus an
//   outstanding-sample count that predicts ready_o.
// ---------------------------------------------------------------------------
module tb_credit_pow_stream;

  localparam int DW      = 4;
  localparam int PWR     = 5;
  localparam int DEPTH_A = 10;
  localparam int DEPTH_B = 3;
  localparam int OW      = DW * PWR;
  localparam int CWA     = $clog2(DEPTH_A + 1);
  localparam int CWB     = $clog2(DEPTH_B + 1);

  logic          clk = 1'b0;
  logic          rst_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [OW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;

  logic [DW-1:0] b_data_i;
  logic          b_valid_i;
  logic          b_ready_o;
  logic [OW-1:0] b_data_o;
  logic          b_valid_o;
  logic          b_ready_i;

`ifdef CREDIT_STATUS_EN
  logic [CWA-1:0] credit_o;
  logic [CWA-1:0] level_o;
  logic [CWB-1:0] b_credit_o;
  logic [CWB-1:0] b_level_o;
`endif

  always #5 clk = ~clk;

  credit_pow_stream #(.DATA_WIDTH(DW), .POWER(PWR), .DEPTH(DEPTH_A)) dut_a (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
`ifdef CREDIT_STATUS_EN
    ,
    .credit_o(credit_o),
    .level_o (level_o)
`endif
  );

  credit_pow_stream #(.DATA_WIDTH(DW), .POWER(PWR), .DEPTH(DEPTH_B)) dut_b (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (b_data_i),
    .valid_i (b_valid_i),
    .ready_o (b_ready_o),
    .data_o  (b_data_o),
    .valid_o (b_valid_o),
    .ready_i (b_ready_i)
`ifdef CREDIT_STATUS_EN
    ,
    .credit_o(b_credit_o),
    .level_o (b_level_o)
`endif
  );

  typedef struct {
    logic [DW-1:0] x;
    logic [OW-1:0] y;
  } vec_t;

  vec_t vecs [6];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state, one slot per DUT (0 = dut_a, 1 = dut_b).
  logic [OW-1:0] q_a [$];
  logic [OW-1:0] q_b [$];
  int            outstanding [2];
  logic          hold        [2];
  logic [OW-1:0] held_data   [2];
  int            err_ready   [2];
  int            err_stable  [2];
  int            err_data    [2];

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [OW-1:0] pow_ref(input logic [DW-1:0] x);
    longint r = 1;
    for (int i = 0; i < PWR; i++) r = r * longint'(x);
    return OW'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [DW-1:0] x, input logic r);
    valid_i = v;
    data_i  = x;
    ready_i = r;
  endtask

  task automatic model_clear();
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < 2; i++) begin
      outstanding[i] = 0;
      hold[i]        = 1'b0;
      held_data[i]   = '0;
      err_ready[i]   = 0;
      err_stable[i]  = 0;
      err_data[i]    = 0;
    end
  endtask

  // One cycle of the reference model, called with the values present
  // between clock edges (inputs applied, outputs settled).
  task automatic score(input int id, input int depth, input logic rdy, input logic vo,
                       input logic [OW-1:0] dout, input logic vi,
                       input logic [DW-1:0] din, input logic ri);
    logic [OW-1:0] want;
    if (rdy !== (outstanding[id] < depth)) err_ready[id]++;
    if (hold[id] && (vo !== 1'b1 || dout !== held_data[id])) err_stable[id]++;
    if (vo === 1'b1 && ri) begin
      if (id == 0) begin
        if (q_a.size() == 0) err_data[id]++;
        else begin
          want = q_a.pop_front();
          if (dout !== want) err_data[id]++;
        end
      end else begin
        if (q_b.size() == 0) err_data[id]++;
        else begin
          want = q_b.pop_front();
          if (dout !== want) err_data[id]++;
        end
      end
      outstanding[id]--;
    end
    if (vi && rdy === 1'b1) begin
      if (id == 0) q_a.push_back(pow_ref(din));
      else         q_b.push_back(pow_ref(din));
      outstanding[id]++;
    end
    hold[id]      = (vo === 1'b1) && !ri;
    held_data[id] = dout;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int            accepted;
    int            lat;
    int            nvalid;
    int            drop;
    int            gaps;
    logic [DW-1:0] xa;
    logic [DW-1:0] xb;
    logic          va, vb, ra, rb;

    vecs[0] = '{x: 4'd3,  y: 20'd243};
    vecs[1] = '{x: 4'd15, y: 20'hB964F};
    vecs[2] = '{x: 4'd0,  y: 20'd0};
    vecs[3] = '{x: 4'd1,  y: 20'd1};
    vecs[4] = '{x: 4'd2,  y: 20'd32};
    vecs[5] = '{x: 4'd7,  y: 20'd16807};

    rst_i = 1'b0;
    apply_stimulus(1'b1, 4'd5, 1'b1);
    b_valid_i = 1'b0;
    b_data_i  = '0;
    b_ready_i = 1'b1;
    model_clear();

    // Reset held for three cycles with valid_i asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("reset_ready", ready_o, 0);
      check_output("reset_valid", valid_o, 0);
    end
    rst_i   = 1'b1;
    valid_i = 1'b0;
    tick();
    check_output("release_ready", ready_o, 1);
`ifdef CREDIT_STATUS_EN
    check_output("release_credit", credit_o, DEPTH_A);
    check_output("release_level", level_o, 0);
`endif
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_o !== 1'b0) nvalid++;
    end
    check_output("reset_no_output", nvalid, 0);

    // Table-driven latency / value vectors.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, vecs[i].x, 1'b1);
      tick();
      valid_i = 1'b0;
      lat = 1;
      while (valid_o !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      check_output("vec_latency", lat, 5);
      check_output("vec_data", data_o, vecs[i].y);
      tick();
      check_output("vec_popped", valid_o, 0);
    end

    // Backpressure: only DEPTH samples fit, then drain in order.
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1, DW'(i), 1'b0);
      if (ready_o === 1'b1) accepted++;
      tick();
    end
    valid_i = 1'b0;
    check_output("bp_accepted", accepted, 10);
    check_output("bp_ready_low", ready_o, 0);
    for (int i = 0; i < 6; i++) tick();
    check_output("bp_head_valid", valid_o, 1);
    ready_i = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j == 1) check_output("bp_credit_return", ready_o, 1);
      check_output("bp_valid", valid_o, 1);
      check_output("bp_data", data_o, pow_ref(DW'(j)));
      tick();
    end
    check_output("bp_drained", valid_o, 0);

    // Streaming at full rate with random samples.
    model_clear();
    drop = 0;
    gaps = 0;
    for (int c = 0; c < 100; c++) begin
      xa = DW'($urandom_range(0, 15));
      apply_stimulus(1'b1, xa, 1'b1);
      if (ready_o !== 1'b1) drop++;
      if (c >= 5 && valid_o !== 1'b1) gaps++;
      score(0, DEPTH_A, ready_o, valid_o, data_o, 1'b1, xa, 1'b1);
      tick();
    end
    valid_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      score(0, DEPTH_A, ready_o, valid_o, data_o, 1'b0, data_i, 1'b1);
      tick();
    end
    check_output("stream_ready_drop", drop, 0);
    check_output("stream_gaps", gaps, 0);
    check_output("stream_data_err", err_data[0], 0);
    check_output("stream_ready_err", err_ready[0], 0);
    check_output("stream_leftover", q_a.size(), 0);

    // Mid-operation reset with 3 samples buffered and 4 in flight.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, DW'(i + 1), 1'b0);
      tick();
    end
    valid_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_output("mid_fifo_valid", valid_o, 1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, DW'(i + 4), 1'b0);
      tick();
    end
    rst_i   = 1'b0;
    valid_i = 1'b0;
    tick();
    rst_i   = 1'b1;
    ready_i = 1'b1;
    tick();
    check_output("mid_ready", ready_o, 1);
`ifdef CREDIT_STATUS_EN
    check_output("mid_credit", credit_o, DEPTH_A);
    check_output("mid_level", level_o, 0);
`endif
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid_o !== 1'b0) nvalid++;
      tick();
    end
    check_output("mid_no_output", nvalid, 0);

    // Random valid/ready on both depths against the reference model.
    model_clear();
    for (int c = 0; c < 10000; c++) begin
      va = ($urandom_range(0, 3) != 0);
      vb = ($urandom_range(0, 3) != 0);
      ra = $urandom_range(0, 1) != 0;
      rb = $urandom_range(0, 1) != 0;
      xa = DW'($urandom_range(0, 15));
      xb = DW'($urandom_range(0, 15));
      apply_stimulus(va, xa, ra);
      b_valid_i = vb;
      b_data_i  = xb;
      b_ready_i = rb;
      score(0, DEPTH_A, ready_o, valid_o, data_o, va, xa, ra);
      score(1, DEPTH_B, b_ready_o, b_valid_o, b_data_o, vb, xb, rb);
      tick();
    end
    apply_stimulus(1'b0, '0, 1'b1);
    b_valid_i = 1'b0;
    b_ready_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      score(0, DEPTH_A, ready_o, valid_o, data_o, 1'b0, data_i, 1'b1);
      score(1, DEPTH_B, b_ready_o, b_valid_o, b_data_o, 1'b0, b_data_i, 1'b1);
      tick();
    end
    check_output("rand10_ready_err", err_ready[0], 0);
    check_output("rand10_stable_err", err_stable[0], 0);
    check_output("rand10_data_err", err_data[0], 0);
    check_output("rand10_leftover", q_a.size(), 0);
    check_output("rand3_ready_err", err_ready[1], 0);
    check_output("rand3_stable_err", err_stable[1], 0);
    check_output("rand3_data_err", err_data[1], 0);
    check_output("rand3_leftover", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
